// File: rtl/fpu_core.sv
// fpu_core: x87-style FPU execution core.
// It implements FLD, FCOM, FCOMP, FCOMPP, FTST and FXAM on an 8-entry 80-bit register stack.
// Define FPU_FILD_EN to enable FILD (opcode 8'h21), which pushes a 32-bit signed integer.
module fpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        execute,
  input  logic [7:0]  instruction,
  input  logic [2:0]  stack_index,
  input  logic [79:0] data_in,
  input  logic [31:0] int_data_in,
  input  logic [15:0] control_in,
  input  logic        control_write,
  output logic        ready,
  output logic        error,
  output logic [79:0] data_out,
  output logic [15:0] status_out
);
  localparam logic [7:0]  OP_FLD     = 8'h20;
  localparam logic [7:0]  OP_FCOM    = 8'h60;
  localparam logic [7:0]  OP_FCOMP   = 8'h61;
  localparam logic [7:0]  OP_FCOMPP  = 8'h62;
  localparam logic [7:0]  OP_FTST    = 8'h63;
  localparam logic [7:0]  OP_FXAM    = 8'h64;
  localparam logic [79:0] INDEFINITE = 80'hFFFF_C000_0000_0000_0000;

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_next;

  logic [79:0] regs [8];
  logic [7:0]  tags;
  logic [2:0]  top;
  logic        c0, c1, c2, c3, sf;
  logic [5:0]  flags;
  logic [15:0] control_reg;
  logic [7:0]  op_q;
  logic [2:0]  idx_q;
  logic [79:0] data_q;

  logic [79:0] st0, st1, cmp_b, push_val, wr_data, fild_val;
  logic [2:0]  push_idx, st1_idx, cmp_idx, wr_idx, code, top_next;
  logic [7:0]  tags_next;
  logic [5:0]  flags_next;
  logic        c0_next, c1_next, c2_next, c3_next, sf_next;
  logic        wr_en, cmp_b_valid, is_cmp, fild_hit, es;

  function automatic logic is_nan(input logic [79:0] v);
    return (v[78:64] == 15'h7FFF) && (v[62:0] != 63'd0);
  endfunction

  function automatic logic is_denorm(input logic [79:0] v);
    return (v[78:64] == 15'd0) && (v[63:0] != 64'd0);
  endfunction

  // FXAM class code as {C3,C2,C0} for a non-empty register
  function automatic logic [2:0] fxam_class(input logic [79:0] v);
    if (v[78:64] == 15'h7FFF) return (v[62:0] != 63'd0) ? 3'b001 : 3'b011;
    if (v[78:64] == 15'd0)    return (v[63:0] == 64'd0) ? 3'b100 : 3'b110;
    return v[63] ? 3'b010 : 3'b000;
  endfunction

  // Ordered compare as {C3,C2,C0}; +0 and -0 compare equal
  function automatic logic [2:0] order(input logic [79:0] a, input logic [79:0] b);
    logic gt;
    if (a[78:0] == 79'd0 && b[78:0] == 79'd0) return 3'b100;
    if (a[79] != b[79]) return a[79] ? 3'b001 : 3'b000;
    if (a[78:0] == b[78:0]) return 3'b100;
    gt = (a[78:0] > b[78:0]) ^ a[79];
    return gt ? 3'b000 : 3'b001;
  endfunction

  assign push_idx = top - 3'd1;
  assign st1_idx  = top + 3'd1;
  assign st0      = regs[top];
  assign st1      = regs[st1_idx];
  assign data_out = st0;
  assign es       = |(flags & ~control_reg[5:0]);
  assign error    = es;
  assign status_out = {es, c3, top, c2, c1, c0, es, sf, flags};
  assign push_val = fild_hit ? fild_val : data_q;

`ifdef FPU_FILD_EN
  localparam logic [7:0] OP_FILD = 8'h21;
  logic [31:0] int_q, fild_mag;
  logic [4:0]  fild_lz;
  logic        unused_bits;

  assign unused_bits = ^control_reg[15:6];
  assign fild_hit    = (op_q == OP_FILD);

  // Capture the integer operand together with the opcode
  always_ff @(posedge clk) begin
    if (reset) int_q <= '0;
    else if (state == IDLE && execute) int_q <= int_data_in;
  end

  // Exact int32 to FP80 conversion by leading-zero normalisation
  always_comb begin
    fild_mag = int_q[31] ? (~int_q + 32'd1) : int_q;
    fild_lz  = 5'd0;
    for (int i = 0; i < 32; i++)
      if (fild_mag[i]) fild_lz = 5'(31 - i);
    fild_val = '0;
    if (fild_mag != 32'd0)
      fild_val = {int_q[31], 15'd16414 - {10'd0, fild_lz}, {fild_mag, 32'd0} << fild_lz};
  end
`else
  logic unused_bits;
  assign unused_bits = ^{control_reg[15:6], int_data_in};
  assign fild_hit    = 1'b0;
  assign fild_val    = '0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: one busy cycle per accepted strobe
  always_comb begin
    state_next = state;
    ready      = (state == IDLE);
    case (state)
      IDLE: if (execute) state_next = EXEC;
      EXEC: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the instruction and its operands when a strobe is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (state == IDLE && execute) begin
      op_q   <= instruction;
      idx_q  <= stack_index;
      data_q <= data_in;
    end
  end

  // Execute-cycle result: push, compare/pop or examine
  always_comb begin
    tags_next  = tags;
    top_next   = top;
    flags_next = flags;
    sf_next    = sf;
    c0_next    = c0;
    c1_next    = c1;
    c2_next    = c2;
    c3_next    = c3;
    wr_en      = 1'b0;
    wr_idx     = push_idx;
    wr_data    = push_val;
    code       = {c3, c2, c0};
    cmp_idx     = top + ((op_q == OP_FCOMPP) ? 3'd1 : idx_q);
    cmp_b       = (op_q == OP_FTST) ? 80'd0 : regs[cmp_idx];
    cmp_b_valid = (op_q == OP_FTST) ? 1'b1 : tags[cmp_idx];
    is_cmp      = (op_q == OP_FCOM) || (op_q == OP_FCOMP) || (op_q == OP_FCOMPP) || (op_q == OP_FTST);
    if (op_q == OP_FLD || fild_hit) begin
      wr_en               = 1'b1;
      top_next            = push_idx;
      tags_next[push_idx] = 1'b1;
      c1_next             = 1'b0;
      if (tags[push_idx]) begin
        wr_data       = INDEFINITE;
        flags_next[0] = 1'b1;
        sf_next       = 1'b1;
        c1_next       = 1'b1;
      end
    end else if (is_cmp) begin
      c1_next = 1'b0;
      if (!tags[top] || !cmp_b_valid) begin
        code          = 3'b111;
        flags_next[0] = 1'b1;
        sf_next       = 1'b1;
      end else begin
        if (is_nan(st0) || is_nan(cmp_b)) begin
          code          = 3'b111;
          flags_next[0] = 1'b1;
        end else begin
          code = order(st0, cmp_b);
        end
        if (is_denorm(st0) || is_denorm(cmp_b)) flags_next[1] = 1'b1;
      end
      if (op_q == OP_FCOMP) begin
        tags_next[top] = 1'b0;
        top_next       = st1_idx;
      end else if (op_q == OP_FCOMPP) begin
        tags_next[top]     = 1'b0;
        tags_next[st1_idx] = 1'b0;
        top_next           = top + 3'd2;
      end
    end else if (op_q == OP_FXAM) begin
      c1_next = st0[79];
      code    = tags[top] ? fxam_class(st0) : 3'b101;
    end
    {c3_next, c2_next, c0_next} = code;
  end

  // Architectural state update; control word loads in any cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      tags        <= '0;
      top         <= '0;
      flags       <= '0;
      sf          <= 1'b0;
      c0          <= 1'b0;
      c1          <= 1'b0;
      c2          <= 1'b0;
      c3          <= 1'b0;
      control_reg <= 16'h037F;
    end else begin
      if (control_write) control_reg <= control_in;
      if (state == EXEC) begin
        if (wr_en) regs[wr_idx] <= wr_data;
        tags  <= tags_next;
        top   <= top_next;
        flags <= flags_next;
        sf    <= sf_next;
        c0    <= c0_next;
        c1    <= c1_next;
        c2    <= c2_next;
        c3    <= c3_next;
      end
    end
  end
endmodule

// File: tb/tb_fpu_core.sv
// tb_fpu_core: directed plus randomized checks of fpu_core against a behavioural stack model.
module tb_fpu_core;
  localparam logic [79:0] ONE  = 80'h3FFF_8000_0000_0000_0000;
  localparam logic [79:0] TWO  = 80'h4000_8000_0000_0000_0000;
  localparam logic [79:0] HALF = 80'h3FFE_8000_0000_0000_0000;
  localparam logic [79:0] NEG1 = 80'hBFFF_8000_0000_0000_0000;
  localparam logic [79:0] QNAN = 80'h7FFF_C000_0000_0000_0000;
  localparam logic [79:0] PINF = 80'h7FFF_8000_0000_0000_0000;
  localparam logic [79:0] DEN  = 80'h0000_4000_0000_0000_0000;
  localparam logic [79:0] INDF = 80'hFFFF_C000_0000_0000_0000;
`ifdef FPU_FILD_EN
  localparam bit FILD_EN = 1'b1;
`else
  localparam bit FILD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, execute, control_write, ready, error;
  logic [7:0]  instruction;
  logic [2:0]  stack_index;
  logic [79:0] data_in, data_out;
  logic [31:0] int_data_in;
  logic [15:0] control_in, status_out;

  int checks = 0;
  int errors = 0;

  logic [79:0] m_regs [8];
  logic [7:0]  m_tags;
  logic [2:0]  m_top;
  logic        m_c0, m_c1, m_c2, m_c3, m_sf;
  logic [5:0]  m_flags;
  logic [15:0] m_ctrl;

  always #5 clk = ~clk;

  fpu_core dut (
    .clk(clk), .reset(reset), .execute(execute), .instruction(instruction),
    .stack_index(stack_index), .data_in(data_in), .int_data_in(int_data_in),
    .control_in(control_in), .control_write(control_write), .ready(ready),
    .error(error), .data_out(data_out), .status_out(status_out)
  );

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic modelEs();
    return |(m_flags & ~m_ctrl[5:0]);
  endfunction

  function automatic logic [15:0] modelStatus();
    logic es;
    es = modelEs();
    return {es, m_c3, m_top, m_c2, m_c1, m_c0, es, m_sf, m_flags};
  endfunction

  function automatic logic [79:0] intToFp(input int x);
    longint mag;
    logic [63:0] m;
    int e;
    if (x == 0) return 80'd0;
    mag = x;
    if (mag < 0) mag = -mag;
    m = 64'(mag);
    e = 16383 + 63;
    while (!m[63]) begin
      m = m << 1;
      e--;
    end
    return {x < 0, 15'(e), m};
  endfunction

  function automatic bit mIsNan(input logic [79:0] v);
    return v[78:64] == 15'h7FFF && v[62:0] != 0;
  endfunction

  function automatic bit mIsDen(input logic [79:0] v);
    return v[78:64] == 15'd0 && v[63:0] != 0;
  endfunction

  function automatic logic [2:0] mClass(input logic [79:0] v);
    if (mIsNan(v)) return 3'b001;
    if (v[78:64] == 15'h7FFF) return 3'b011;
    if (v[78:0] == 0) return 3'b100;
    if (mIsDen(v)) return 3'b110;
    if (!v[63]) return 3'b000;
    return 3'b010;
  endfunction

  // Ordering via signed numeric keys: negate magnitude for negative sign
  function automatic logic [2:0] mOrder(input logic [79:0] a, input logic [79:0] b);
    logic signed [80:0] ka, kb;
    ka = {2'b00, a[78:0]};
    kb = {2'b00, b[78:0]};
    if (a[79]) ka = -ka;
    if (b[79]) kb = -kb;
    if (ka > kb) return 3'b000;
    if (ka < kb) return 3'b001;
    return 3'b100;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_tags = '0; m_top = '0; m_flags = '0; m_sf = 0;
    m_c0 = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
    m_ctrl = 16'h037F;
  endtask

  task automatic modelExec(input logic [7:0] op, input logic [2:0] idx, input logic [79:0] d, input int intd);
    logic [79:0] a, b, v;
    logic av, bv;
    logic [2:0] bi, nt, code;
    if (op == 8'h20 || (FILD_EN && op == 8'h21)) begin
      v  = (op == 8'h21) ? intToFp(intd) : d;
      nt = m_top - 3'd1;
      m_c1 = 0;
      if (m_tags[nt]) begin
        v = INDF; m_flags[0] = 1; m_sf = 1; m_c1 = 1;
      end
      m_regs[nt] = v; m_tags[nt] = 1; m_top = nt;
    end else if (op >= 8'h60 && op <= 8'h63) begin
      a = m_regs[m_top]; av = m_tags[m_top];
      if (op == 8'h63) begin
        b = 80'd0; bv = 1;
      end else begin
        bi = m_top + ((op == 8'h62) ? 3'd1 : idx);
        b = m_regs[bi]; bv = m_tags[bi];
      end
      m_c1 = 0;
      if (!av || !bv) begin
        code = 3'b111; m_flags[0] = 1; m_sf = 1;
      end else if (mIsNan(a) || mIsNan(b)) begin
        code = 3'b111; m_flags[0] = 1;
      end else begin
        code = mOrder(a, b);
      end
      if (av && bv && (mIsDen(a) || mIsDen(b))) m_flags[1] = 1;
      {m_c3, m_c2, m_c0} = code;
      for (int p = 0; p < ((op == 8'h61) ? 1 : (op == 8'h62) ? 2 : 0); p++) begin
        m_tags[m_top] = 0;
        m_top = m_top + 3'd1;
      end
    end else if (op == 8'h64) begin
      a = m_regs[m_top];
      m_c1 = a[79];
      {m_c3, m_c2, m_c0} = m_tags[m_top] ? mClass(a) : 3'b101;
    end
  endtask

  task automatic checkAll(input string tag);
    logic [2:0] i1;
    i1 = m_top + 3'd1;
    checkOutput({tag, "_status"}, status_out, modelStatus());
    checkOutput({tag, "_data"}, data_out, m_regs[m_top]);
    checkOutput({tag, "_st0"}, dut.st0, m_regs[m_top]);
    checkOutput({tag, "_st1"}, dut.st1, m_regs[i1]);
    checkOutput({tag, "_error"}, error, modelEs());
    checkOutput({tag, "_ready"}, ready, 1);
  endtask

  task automatic checkCodes(input string tag, input logic [2:0] exp);
    checkOutput(tag, {status_out[14], status_out[10], status_out[8]}, exp);
  endtask

  task automatic doReset();
    reset = 1; execute = 0; control_write = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    modelReset();
  endtask

  task automatic waitReady();
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ready_wait", ready, 1);
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] idx, input logic [79:0] d,
                               input int intd, input bit hold);
    waitReady();
    @(negedge clk);
    execute = 1; instruction = op; stack_index = idx; data_in = d; int_data_in = intd;
    @(posedge clk); #1;
    checkOutput("ready_busy", ready, 0);
    if (hold) begin
      instruction = 8'h20; data_in = TWO;
    end else begin
      execute = 0;
    end
    @(posedge clk); #1;
    execute = 0;
    modelExec(op, idx, d, intd);
    checkAll($sformatf("op%h", op));
  endtask

  task automatic fld(input logic [79:0] d);
    applyStimulus(8'h20, 3'd0, d, 0, 0);
  endtask

  task automatic applyControl(input logic [15:0] v);
    @(negedge clk);
    control_in = v; control_write = 1;
    @(posedge clk); #1;
    control_write = 0;
    m_ctrl = v;
  endtask

  function automatic logic [79:0] randVal();
    logic [63:0] r;
    logic [2:0] k;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: return {r[0], 79'd0};
      1: return {r[0], 15'h7FFF, 64'h8000_0000_0000_0000};
      2: return {r[0], 15'h7FFF, 2'b11, r[61:0]};
      3: return {r[0], 15'd0, 1'b0, r[62:1], 1'b1};
      4: return {r[0], 15'(16'h3FFF), 1'b0, r[62:0]};
      5: begin
        k = 3'($urandom_range(0, 7));
        return m_regs[k];
      end
      6: return {r[0], 15'h3FFF, 1'b1, 61'd0, r[2:1]};
      default: return {r[0], 15'($urandom_range(16'h3FF0, 16'h4010)), 1'b1, r[62:0]};
    endcase
  endfunction

  initial begin
    logic [7:0] op;
    logic [7:0] ops [7];
    int intd;
    ops = '{8'h20, 8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h21};
    reset = 1; execute = 0; control_write = 0; instruction = 0; stack_index = 0;
    data_in = 0; int_data_in = 0; control_in = 0;

    doReset();
    checkAll("reset");
    applyStimulus(8'h64, 3'd0, 80'd0, 0, 0);
    checkCodes("fxam_empty", 3'b101);

    doReset(); fld(ONE); fld(ONE);
    applyStimulus(8'h60, 3'd1, 80'd0, 0, 0); checkCodes("fcom_eq", 3'b100);
    doReset(); fld(ONE); fld(TWO);
    applyStimulus(8'h60, 3'd1, 80'd0, 0, 0); checkCodes("fcom_gt", 3'b000);
    doReset(); fld(ONE); fld(HALF);
    applyStimulus(8'h60, 3'd1, 80'd0, 0, 0); checkCodes("fcom_lt", 3'b001);
    doReset(); fld(ONE); fld(QNAN);
    applyStimulus(8'h60, 3'd1, 80'd0, 0, 0); checkCodes("fcom_nan", 3'b111);
    checkOutput("fcom_nan_ie", status_out[0], 1);

    doReset();
    fld(TWO);  applyStimulus(8'h63, 3'd0, 80'd0, 0, 0); checkCodes("ftst_pos", 3'b000);
    fld(NEG1); applyStimulus(8'h63, 3'd0, 80'd0, 0, 0); checkCodes("ftst_neg", 3'b001);
    fld(80'd0); applyStimulus(8'h63, 3'd0, 80'd0, 0, 0); checkCodes("ftst_zero", 3'b100);

    doReset();
    fld(80'd0); applyStimulus(8'h64, 3'd0, 80'd0, 0, 0); checkCodes("fxam_zero", 3'b100);
    fld(ONE);   applyStimulus(8'h64, 3'd0, 80'd0, 0, 0); checkCodes("fxam_norm", 3'b010);
    fld(PINF);  applyStimulus(8'h64, 3'd0, 80'd0, 0, 0); checkCodes("fxam_inf", 3'b011);
    fld(QNAN);  applyStimulus(8'h64, 3'd0, 80'd0, 0, 0); checkCodes("fxam_nan", 3'b001);
    fld(DEN);   applyStimulus(8'h64, 3'd0, 80'd0, 0, 0); checkCodes("fxam_den", 3'b110);
    fld(NEG1);  applyStimulus(8'h64, 3'd0, 80'd0, 0, 0);
    checkOutput("fxam_c1", status_out[9], 1);

    doReset(); fld(ONE); fld(TWO);
    applyStimulus(8'h61, 3'd1, 80'd0, 0, 0); checkCodes("fcomp_gt", 3'b000);
    checkOutput("fcomp_top", status_out[13:11], 3'd7);
    fld(ONE); fld(HALF);
    applyStimulus(8'h62, 3'd5, 80'd0, 0, 0); checkCodes("fcompp_lt", 3'b001);
    checkOutput("fcompp_top", status_out[13:11], 3'd7);

    doReset();
    for (int i = 0; i < 9; i++) fld(ONE);
    checkOutput("ovf_ie", status_out[0], 1);
    checkOutput("ovf_sf", status_out[6], 1);
    checkOutput("ovf_c1", status_out[9], 1);
    checkOutput("ovf_indef", data_out, INDF);
    checkOutput("ovf_err_masked", error, 0);
    applyControl(16'h037E);
    checkOutput("ovf_err_unmasked", error, 1);
    checkOutput("ovf_b", status_out[15], 1);

    doReset();
    applyStimulus(8'h20, 3'd0, ONE, 0, 1);
    checkOutput("hold_top", status_out[13:11], 3'd7);
    applyStimulus(8'h7F, 3'd2, TWO, 0, 0);

    @(negedge clk);
    execute = 1; instruction = 8'h20; data_in = TWO;
    @(posedge clk); #1;
    execute = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    modelReset();
    checkAll("abort");

`ifdef FPU_FILD_EN
    applyStimulus(8'h21, 3'd0, 80'd0, -3, 0);
    checkOutput("fild_m3", data_out, 80'hC000_C000_0000_0000_0000);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) doReset();
      if ($urandom_range(0, 29) == 0) applyControl({10'h00D, 6'($urandom)});
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 15) == 0) op = 8'($urandom_range(8'h80, 8'hFF));
      case ($urandom_range(0, 4))
        0: intd = 0;
        1: intd = -1;
        2: intd = 32'h8000_0000;
        default: intd = int'($urandom);
      endcase
      applyStimulus(op, 3'($urandom_range(0, 7)), randVal(), intd, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
